// File: rtl/div_share_arbiter.sv
// Round-robin front end that time-shares one combinational hp_div between NREQ
// requesters, with an operand register ahead of the divider and a result register behind it.

module hp_div #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic [NEXP+NSIG:0] a,
    input  logic [NEXP+NSIG:0] b,
    output logic [NEXP+NSIG:0] q,
    output logic [5:0]         bfFlags,
    output logic [4:0]         exception
);
    // exception = {invalid, div_by_zero, overflow, underflow, inexact}
    // bfFlags   = {nan, inf, zero, subnormal, normal, sign} of q
    localparam int W    = NEXP + NSIG + 1;
    localparam int MW   = NSIG + 1;
    localparam int NW   = NSIG + 4;
    localparam int DW   = MW + NW;
    localparam int BIAS = (1 << (NEXP - 1)) - 1;
    localparam int EMAX = (1 << NEXP) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    function automatic int lzc(input logic [MW-1:0] m);
        int  n;
        logic f;
        n = 0;
        f = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!f) begin
                if (m[i]) f = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

    logic            sa, sb, sq;
    logic [NEXP-1:0] ea_f, eb_f, ebase;
    logic [NSIG-1:0] fa, fb;
    logic            a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [MW-1:0]   ma, mb, ma_n, mb_n;
    int              lza, lzb, ea, eb, e, ebias, sh;
    logic [DW-1:0]   num, den, rem;
    logic [NW-1:0]   quo, nrm, shd;
    logic            sticky0, lost, guard, stk, rnd, inexact, tiny;
    logic [NEXP+NSIG-1:0] mag;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1];
        sq     = sa ^ sb;
        ea_f   = a[W-2:NSIG];
        eb_f   = b[W-2:NSIG];
        fa     = a[NSIG-1:0];
        fb     = b[NSIG-1:0];
        a_nan  = (ea_f == '1) && (fa != '0);
        b_nan  = (eb_f == '1) && (fb != '0);
        a_snan = a_nan && !fa[NSIG-1];
        b_snan = b_nan && !fb[NSIG-1];
        a_inf  = (ea_f == '1) && (fa == '0);
        b_inf  = (eb_f == '1) && (fb == '0);
        a_zero = (ea_f == '0) && (fa == '0);
        b_zero = (eb_f == '0) && (fb == '0);

        // Normalise subnormal inputs so the quotient always lands in (0.5, 2).
        ma   = {ea_f != '0, fa};
        mb   = {eb_f != '0, fb};
        lza  = lzc(ma);
        lzb  = lzc(mb);
        ma_n = ma << lza;
        mb_n = mb << lzb;
        ea   = ((ea_f == '0) ? 1 : int'(ea_f)) - lza;
        eb   = ((eb_f == '0) ? 1 : int'(eb_f)) - lzb;

        num     = DW'(ma_n) << (NW - 1);
        den     = (mb_n == '0) ? DW'(1) : DW'(mb_n);
        quo     = NW'(num / den);
        rem     = num % den;
        sticky0 = (rem != '0);
        if (quo[NW-1]) begin
            nrm = quo;
            e   = ea - eb;
        end else begin
            nrm = {quo[NW-2:0], 1'b0};
            e   = ea - eb - 1;
        end

        ebias = e + BIAS;
        tiny  = (ebias < 1);
        sh    = tiny ? (1 - ebias) : 0;
        if (sh > NW) sh = NW;
        shd   = nrm >> sh;
        lost  = (nrm & ~({NW{1'b1}} << sh)) != '0;
        guard = shd[2];
        stk   = shd[1] | shd[0] | lost | sticky0;
        rnd   = guard & (stk | shd[3]);
        inexact = guard | stk;
        // Hidden bit adds into the exponent field; rounding carry may bump it further.
        ebase = tiny ? '0 : NEXP'(ebias - 1);
        mag   = {ebase, {NSIG{1'b0}}} + (NEXP+NSIG)'(shd[NW-1:3]) + (NEXP+NSIG)'(rnd);

        q         = '0;
        exception = '0;
        if (a_nan || b_nan) begin
            q            = QNAN;
            exception[4] = a_snan | b_snan;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            q            = QNAN;
            exception[4] = 1'b1;
        end else if (a_inf || b_zero) begin
            q            = {sq, {NEXP{1'b1}}, {NSIG{1'b0}}};
            exception[3] = b_zero & !a_inf;
        end else if (a_zero || b_inf) begin
            q = {sq, {(W-1){1'b0}}};
        end else if (ebias >= EMAX || mag[NEXP+NSIG-1:NSIG] == '1) begin
            q         = {sq, {NEXP{1'b1}}, {NSIG{1'b0}}};
            exception = 5'b00101;
        end else begin
            q            = {sq, mag};
            exception[1] = tiny & inexact;
            exception[0] = inexact;
        end
    end

    assign bfFlags = {(q[W-2:NSIG] == '1) && (q[NSIG-1:0] != '0),
                      (q[W-2:NSIG] == '1) && (q[NSIG-1:0] == '0),
                      (q[W-2:NSIG] == '0) && (q[NSIG-1:0] == '0),
                      (q[W-2:NSIG] == '0) && (q[NSIG-1:0] != '0),
                      (q[W-2:NSIG] != '0) && (q[W-2:NSIG] != '1),
                      q[W-1]};
endmodule

module div_share_arbiter #(
    parameter int NEXP = 8,
    parameter int NSIG = 7,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*(NEXP+NSIG+1)-1:0]  req_a,
    input  logic [NREQ*(NEXP+NSIG+1)-1:0]  req_b,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [IDW-1:0]                 resp_id,
    output logic [NEXP+NSIG:0]             resp_q,
    output logic [5:0]                     resp_flags,
    output logic [4:0]                     resp_exc,
    output logic                           busy,
    output logic [15:0]                    op_count
);
    localparam int W = NEXP + NSIG + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, rid_q, rid_d, grant_id;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, quo_q, quo_d, div_q;
    logic [5:0]     flg_q, flg_d, div_flags;
    logic [4:0]     exc_q, exc_d, div_exc;
    logic [15:0]    cnt_q, cnt_d;
    logic           grant_vld;
    int             idx;

    // Divider sees only the operand register, so the long path is flop-to-flop.
    hp_div #(.NEXP(NEXP), .NSIG(NSIG)) u_div (
        .a(opa_q), .b(opb_q), .q(div_q), .bfFlags(div_flags), .exception(div_exc)
    );

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        id_d     = id_q;
        rid_d    = rid_q;
        quo_d    = quo_q;
        flg_d    = flg_q;
        exc_d    = exc_q;
        cnt_d    = cnt_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    opa_d    = req_a[int'(grant_id)*W +: W];
                    opb_d    = req_b[int'(grant_id)*W +: W];
                    id_d     = grant_id;
                    rr_ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                quo_d   = div_q;
                flg_d   = div_flags;
                exc_d   = div_exc;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            id_q     <= '0;
            rid_q    <= '0;
            quo_q    <= '0;
            flg_q    <= '0;
            exc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            id_q     <= id_d;
            rid_q    <= rid_d;
            quo_q    <= quo_d;
            flg_q    <= flg_d;
            exc_q    <= exc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = rid_q;
    assign resp_q     = quo_q;
    assign resp_flags = flg_q;
    assign resp_exc   = exc_q;
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: a cycle model predicts grants, handshakes and
// results; known quotients are checked against constants, the rest against hp_div.
module tb_div_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              resp_valid, resp_ready, busy;
    logic [1:0]        resp_id;
    logic [W-1:0]      resp_q;
    logic [5:0]        resp_flags;
    logic [4:0]        resp_exc;
    logic [15:0]       op_count;

    logic [W-1:0] ref_q [NREQ];
    logic [5:0]   ref_f [NREQ];
    logic [4:0]   ref_e [NREQ];

    always #5 clk = ~clk;

    div_share_arbiter #(.NEXP(8), .NSIG(7), .NREQ(NREQ), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_q(resp_q), .resp_flags(resp_flags), .resp_exc(resp_exc),
        .busy(busy), .op_count(op_count)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_ref
        hp_div #(.NEXP(8), .NSIG(7)) u_ref (
            .a(req_a[i*W +: W]), .b(req_b[i*W +: W]),
            .q(ref_q[i]), .bfFlags(ref_f[i]), .exception(ref_e[i])
        );
    end

    typedef struct {
        int          id;
        logic [15:0] q;
        logic [5:0]  f;
        logic [4:0]  e;
        int          t;
    } exp_t;

    exp_t          sb[$];
    int            glog_id[$], glog_cyc[$];
    int            total = 0, bad = 0;
    int            cyc = 0, m_st = 0, m_rr = 0, n_resp = 0;
    logic [15:0]   m_cnt = '0;
    logic          m_first = 1'b0, hs_any = 1'b0;
    logic [NREQ-1:0] hs = '0, keep = '0;
    logic [15:0]   last_q;
    logic [5:0]    last_f;
    logic [4:0]    last_e;
    int            last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Cycle model: predicts grant, handshake and response ordering for this cycle.
    task automatic mon();
        logic [NREQ-1:0] er;
        int g, ix;
        exp_t x;
        cyc++;
        if (rst) begin
            m_st = 0; m_rr = 0; m_cnt = '0; sb.delete();
            return;
        end
        er = '0;
        g  = -1;
        if (m_st == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                ix = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[ix]) g = ix;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_st != 0);
        chk("resp_valid", resp_valid, m_st == 2);
        chk("op_count", op_count, m_cnt);
        case (m_st)
            0: if (g >= 0) begin
                x.id = g; x.q = ref_q[g]; x.f = ref_f[g]; x.e = ref_e[g]; x.t = cyc;
                sb.push_back(x);
                hs[g] = 1'b1; hs_any = 1'b1;
                glog_id.push_back(g); glog_cyc.push_back(cyc);
                m_rr = (g + 1) % NREQ;
                m_st = 1;
            end
            1: begin m_st = 2; m_first = 1'b1; end
            default: begin
                if (m_first) chk("latency", cyc - sb[0].t, 2);
                m_first = 1'b0;
                chk("resp_id", resp_id, sb[0].id);
                chk("resp_q", resp_q, sb[0].q);
                chk("resp_flags", resp_flags, sb[0].f);
                chk("resp_exc", resp_exc, sb[0].e);
                if (resp_ready) begin
                    last_q = resp_q; last_f = resp_flags; last_e = resp_exc; last_id = int'(resp_id);
                    void'(sb.pop_front());
                    m_cnt++; n_resp++; m_st = 0;
                end
            end
        endcase
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                hs[i] = 1'b0;
                if (keep[i]) req_a[i*W +: W] = req_a[i*W +: W] + 16'h0080;
                else         req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_resp(input int target, input string tag);
        int n;
        n = 0;
        while (n_resp < target && n < 60) begin tick(); n++; end
        chk(tag, n_resp, target);
    endtask

    task automatic wait_rv(input string tag);
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        chk(tag, resp_valid, 1);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        tick();
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rr"}, dut.rr_ptr_q, 0);
        chk({tag, "_cnt"}, op_count, 0);
        rst = 1'b0;
    endtask

    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input string tag);
        set_op(i, a, b);
        wait_resp(n_resp + 1, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0, nb;
        logic [15:0] cnt0, q0;
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; resp_ready = 1'b1;
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rv", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_q", resp_q, 0);
        chk("rst_flags", resp_flags, 0);
        chk("rst_exc", resp_exc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", op_count, 0);
        chk("rst_rr", dut.rr_ptr_q, 0);
        req_valid = '0; rst = 1'b0;
        tick();

        // 6.0 / 2.0
        do_op(0, 16'h40C0, 16'h4000, "single_done");
        chk("single_q", last_q, 16'h4040);
        chk("single_id", last_id, 0);
        chk("single_flags", last_f, 6'h02);
        chk("single_exc", last_e, 5'h00);
        chk("single_cnt", op_count, 1);

        // Round robin with all requesters saturated
        pulse_reset("rrrst");
        glog_id.delete(); glog_cyc.delete();
        keep = '1;
        set_op(0, 16'h3F90, 16'h4040);
        set_op(1, 16'h3FA0, 16'h40A0);
        set_op(2, 16'h3FB0, 16'h40E0);
        set_op(3, 16'h3FC0, 16'h3FC0);
        for (int n = 0; n < 40 && glog_id.size() < 5; n++) tick();
        keep = '0; req_valid = '0;
        for (int n = 0; n < 10 && m_st != 0; n++) tick();
        chk("rr_grants", glog_id.size() >= 5, 1);
        for (int k = 0; k < 5 && k < glog_id.size(); k++) begin
            chk("rr_id", glog_id[k], k % 4);
            if (k > 0) chk("rr_gap", glog_cyc[k] - glog_cyc[k-1], 3);
        end

        // Backpressure: result must hold and nobody else gets granted
        resp_ready = 1'b0;
        nb = n_resp;
        set_op(2, 16'h4120, 16'h4040);
        wait_rv("bp_rv");
        set_op(1, 16'h4000, 16'h3F80);
        cnt0 = op_count; q0 = resp_q;
        repeat (5) tick();
        chk("bp_q_hold", resp_q, q0);
        chk("bp_id", resp_id, 2);
        chk("bp_cnt", op_count, cnt0);
        chk("bp_noresp", n_resp, nb);
        resp_ready = 1'b1;
        wait_resp(nb + 2, "bp_drain");
        chk("bp_cnt_after", op_count, cnt0 + 16'd2);

        // Special operands, compared against constants and the reference instance
        do_op(3, 16'h3F80, 16'h0000, "sp_div0");
        chk("div0_q", last_q, 16'h7F80);
        chk("div0_exc", last_e, 5'h08);
        chk("div0_flags", last_f, 6'h10);
        do_op(3, 16'h7FC0, 16'h3F80, "sp_nan");
        chk("nan_q", last_q, 16'h7FC0);
        chk("nan_exc", last_e, 5'h00);
        chk("nan_flags", last_f, 6'h20);
        do_op(3, 16'h7F81, 16'h3F80, "sp_snan");
        chk("snan_q", last_q, 16'h7FC0);
        chk("snan_exc", last_e, 5'h10);
        do_op(3, 16'h0001, 16'h4000, "sp_sub");
        chk("sub_q", last_q, 16'h0000);
        chk("sub_exc", last_e, 5'h03);
        chk("sub_flags", last_f, 6'h08);
        do_op(3, 16'h3F80, 16'h4040, "sp_third");
        chk("third_q", last_q, 16'h3EAB);
        chk("third_exc", last_e, 5'h01);

        // Reset while EXEC
        n0 = n_resp;
        hs_any = 1'b0;
        set_op(0, 16'h3F80, 16'h4000);
        for (int n = 0; n < 10 && !hs_any; n++) tick();
        chk("exec_hs", hs_any, 1);
        pulse_reset("rst_exec");
        repeat (4) tick();
        chk("exec_noresp", n_resp, n0);

        // Reset while RESP
        resp_ready = 1'b0;
        set_op(1, 16'h4040, 16'h4000);
        wait_rv("resp_rv");
        pulse_reset("rst_resp");
        resp_ready = 1'b1;
        repeat (4) tick();
        chk("resp_noresp", n_resp, n0);

        // Counter wrap
        force dut.cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        release dut.cnt_q;
        tick();
        chk("wrap_pre", op_count, 16'hFFFF);
        do_op(2, 16'h4000, 16'h4000, "wrap_done");
        chk("wrap_cnt", op_count, 16'h0000);
        chk("wrap_q", last_q, 16'h3F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
